// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for VGA pong (IDLE/SERVE/PLAY/POINT/OVER), scores, ball/paddle gating.
// Optional feature macro PONG_AUTO_SERVE_EN: SERVE auto-launches after AUTO_SERVE_FRAMES frame ticks.
// Ports: clk, rst (sync, active-high); frame_tick, start_btn, serve_btn, miss_left, miss_right in;
//        ball_rst, ball_run, serve_dir_l, paddles_en, score_l[3:0], score_r[3:0], state[2:0],
//        winner_valid, winner_r out (all registered).
module pong_game_ctrl #(
  parameter int WIN_SCORE = 11,
  parameter int POINT_FRAMES = 60
`ifdef PONG_AUTO_SERVE_EN
  , parameter int AUTO_SERVE_FRAMES = 120
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       serve_btn,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_rst,
  output logic       ball_run,
  output logic       serve_dir_l,
  output logic       paddles_en,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       winner_valid,
  output logic       winner_r
);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;
  state_t cur, nxt;
  logic start_q, serve_q, start_e, serve_e, dir_n, brst_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] sl_n, sr_n;
  assign start_e = start_btn & ~start_q;
  assign serve_e = serve_btn & ~serve_q;
  assign state = cur;
  always_comb begin
    nxt = cur;
    cnt_n = cnt;
    sl_n = score_l;
    sr_n = score_r;
    dir_n = serve_dir_l;
    brst_n = 1'b0;
    if (start_e) begin
      nxt = SERVE;
      cnt_n = '0;
      sl_n = '0;
      sr_n = '0;
      dir_n = 1'b0;
      brst_n = 1'b1;
    end else begin
      case (cur)
        SERVE: begin
`ifdef PONG_AUTO_SERVE_EN
          if (serve_e || (frame_tick && cnt == 8'(AUTO_SERVE_FRAMES - 1))) begin
            nxt = PLAY;
            cnt_n = '0;
          end else if (frame_tick) cnt_n = cnt + 8'd1;
`else
          if (serve_e) nxt = PLAY;
`endif
        end
        PLAY: begin
          if (miss_left || miss_right) nxt = POINT;
          // a simultaneous double miss is treated as a void rally
          if (miss_left && !miss_right) begin
            sr_n = (score_r == 4'(WIN_SCORE)) ? score_r : score_r + 4'd1;
            dir_n = 1'b1;
          end
          if (miss_right && !miss_left) begin
            sl_n = (score_l == 4'(WIN_SCORE)) ? score_l : score_l + 4'd1;
            dir_n = 1'b0;
          end
        end
        POINT: begin
          if (frame_tick && cnt == 8'(POINT_FRAMES - 1)) begin
            cnt_n = '0;
            nxt = (score_l == 4'(WIN_SCORE) || score_r == 4'(WIN_SCORE)) ? OVER : SERVE;
            brst_n = (nxt == SERVE);
          end else if (frame_tick) cnt_n = cnt + 8'd1;
        end
        default: nxt = cur;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= IDLE;
      start_q <= 1'b1;
      serve_q <= 1'b1;
      cnt <= '0;
      score_l <= '0;
      score_r <= '0;
      serve_dir_l <= 1'b0;
      ball_rst <= 1'b0;
      ball_run <= 1'b0;
      paddles_en <= 1'b0;
      winner_valid <= 1'b0;
      winner_r <= 1'b0;
    end else begin
      cur <= nxt;
      start_q <= start_btn;
      serve_q <= serve_btn;
      cnt <= cnt_n;
      score_l <= sl_n;
      score_r <= sr_n;
      serve_dir_l <= dir_n;
      ball_rst <= brst_n;
      ball_run <= (nxt == PLAY);
      paddles_en <= (nxt inside {SERVE, PLAY, POINT});
      winner_valid <= (nxt == OVER);
      winner_r <= (nxt == OVER) && (sr_n == 4'(WIN_SCORE));
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scoreboard bench for pong_game_ctrl.
module tb_pong_game_ctrl;
  logic clk = 0, rst = 1, frame_tick = 0, start_btn = 0, serve_btn = 0, miss_left = 0, miss_right = 0;
  logic ball_rst, ball_run, serve_dir_l, paddles_en, winner_valid, winner_r;
  logic [3:0] score_l, score_r;
  logic [2:0] state;
  typedef struct {string tag; logic [23:0] exp;} exp_t;
  exp_t sbq[$];
  int checks = 0, errors = 0, brst_cnt = 0, exp_brst = 0;
  always #5 clk = ~clk;
  always @(negedge clk) brst_cnt <= brst_cnt + int'(ball_rst);
  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn), .serve_btn(serve_btn),
    .miss_left(miss_left), .miss_right(miss_right), .ball_rst(ball_rst), .ball_run(ball_run),
    .serve_dir_l(serve_dir_l), .paddles_en(paddles_en), .score_l(score_l), .score_r(score_r),
    .state(state), .winner_valid(winner_valid), .winner_r(winner_r)
  );
  function automatic logic [15:0] st(input logic [2:0] s, input logic [3:0] l, input logic [3:0] r,
                                     input logic d, input logic run, input logic pad, input logic wv, input logic wr);
    return {s, l, r, d, run, pad, wv, wr};
  endfunction
  task automatic push(input string tag, input logic [15:0] s);
    exp_t e;
    e.tag = tag;
    e.exp = {s, 8'(exp_brst)};
    sbq.push_back(e);
  endtask
  task automatic chk();
    exp_t e;
    logic [23:0] o;
    #1;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    e = sbq.pop_front();
    o = {state, score_l, score_r, serve_dir_l, ball_run, paddles_en, winner_valid, winner_r, 8'(brst_cnt)};
    assert (o === e.exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", e.tag, o, e.exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_start();
    start_btn = 1; cyc(1); start_btn = 0;
  endtask
  task automatic press_serve();
    serve_btn = 1; cyc(1); serve_btn = 0;
  endtask
  task automatic miss(input logic l, input logic r);
    miss_left = l; miss_right = r; cyc(1); miss_left = 0; miss_right = 0;
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1; cyc(1); frame_tick = 0; cyc(1);
    end
  endtask
  initial begin
    start_btn = 1;
    cyc(3);
    push("reset", st(0, 0, 0, 0, 0, 0, 0, 0)); chk();
    rst = 0;
    cyc(2);
    push("held_start_no_edge", st(0, 0, 0, 0, 0, 0, 0, 0)); chk();
    start_btn = 0;
    cyc(1);
    push("idle_after_release", st(0, 0, 0, 0, 0, 0, 0, 0)); chk();
    exp_brst++;
    push("start_to_serve", st(1, 0, 0, 0, 0, 1, 0, 0)); press_start(); chk();
    push("miss_in_serve", st(1, 0, 0, 0, 0, 1, 0, 0)); miss(0, 1); chk();
    push("serve_to_play", st(2, 0, 0, 0, 1, 1, 0, 0)); press_serve(); chk();
    for (int k = 1; k <= 3; k++) begin
      push("miss_right_point", st(3, 4'(k), 0, 0, 0, 1, 0, 0)); miss(0, 1); chk();
      push("miss_in_point", st(3, 4'(k), 0, 0, 0, 1, 0, 0)); miss(1, 0); chk();
      push("point_hold_59", st(3, 4'(k), 0, 0, 0, 1, 0, 0)); ticks(59); chk();
      exp_brst++;
      push("point_to_serve", st(1, 4'(k), 0, 0, 0, 1, 0, 0)); ticks(1); chk();
      push("reserve_play", st(2, 4'(k), 0, 0, 1, 1, 0, 0)); press_serve(); chk();
    end
    push("miss_left_point", st(3, 3, 1, 1, 0, 1, 0, 0)); miss(1, 0); chk();
    exp_brst++;
    push("point_to_serve_l", st(1, 3, 1, 1, 0, 1, 0, 0)); ticks(60); chk();
    push("serve_play_l", st(2, 3, 1, 1, 1, 1, 0, 0)); press_serve(); chk();
    push("double_miss", st(3, 3, 1, 1, 0, 1, 0, 0)); miss(1, 1); chk();
    exp_brst++;
    push("double_miss_serve", st(1, 3, 1, 1, 0, 1, 0, 0)); ticks(60); chk();
    for (int r = 2; r <= 11; r++) begin
      push("play_r", st(2, 3, 4'(r - 1), 1, 1, 1, 0, 0)); press_serve(); chk();
      push("point_r", st(3, 3, 4'(r), 1, 0, 1, 0, 0)); miss(1, 0); chk();
      if (r < 11) begin
        exp_brst++;
        push("point_r_serve", st(1, 3, 4'(r), 1, 0, 1, 0, 0));
      end else push("game_over", st(4, 3, 11, 1, 0, 0, 1, 1));
      ticks(60); chk();
    end
    push("miss_in_over", st(4, 3, 11, 1, 0, 0, 1, 1)); miss(1, 1); miss(0, 1); chk();
    exp_brst++;
    push("over_restart", st(1, 0, 0, 0, 0, 1, 0, 0)); press_start(); chk();
    push("play_again", st(2, 0, 0, 0, 1, 1, 0, 0)); press_serve(); chk();
    push("point_again", st(3, 1, 0, 0, 0, 1, 0, 0)); miss(0, 1); chk();
    exp_brst++;
    push("serve_again", st(1, 1, 0, 0, 0, 1, 0, 0)); ticks(60); chk();
    push("play_third", st(2, 1, 0, 0, 1, 1, 0, 0)); press_serve(); chk();
    start_btn = 1; miss_left = 1; cyc(1); start_btn = 0; miss_left = 0;
    exp_brst++;
    push("start_beats_miss", st(1, 0, 0, 0, 0, 1, 0, 0)); chk();
    push("play_pre_rst", st(2, 0, 0, 0, 1, 1, 0, 0)); press_serve(); chk();
    push("point_pre_rst", st(3, 1, 0, 0, 0, 1, 0, 0)); miss(0, 1); chk();
    rst = 1; cyc(1); rst = 0;
    push("mid_match_reset", st(0, 0, 0, 0, 0, 0, 0, 0)); chk();
    push("miss_in_idle", st(0, 0, 0, 0, 0, 0, 0, 0)); miss(1, 0); miss(0, 1); chk();
    exp_brst++;
    push("start_for_auto", st(1, 0, 0, 0, 0, 1, 0, 0)); press_start(); chk();
`ifdef PONG_AUTO_SERVE_EN
    push("auto_hold_119", st(1, 0, 0, 0, 0, 1, 0, 0)); ticks(119); chk();
    push("auto_serve_120", st(2, 0, 0, 0, 1, 1, 0, 0)); ticks(1); chk();
`else
    push("no_auto_serve_300", st(1, 0, 0, 0, 0, 1, 0, 0)); ticks(300); chk();
`endif
    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d entries left, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
